// File: rtl/sa_ctrl_pkg.sv
// ============================================================================
// Module      : sa_ctrl_pkg
// Description : Shared state and PE command encodings for the systolic
//               array sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sa_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FEED  = 3'd1,
      WAIT  = 3'd2,
      FLUSH = 3'd3,
      DRAIN = 3'd4,
      DONE  = 3'd5
   } state_e;

   localparam logic [1:0] CMD_IDLE  = 2'b00;
   localparam logic [1:0] CMD_ACC   = 2'b01;
   localparam logic [1:0] CMD_FLUSH = 2'b11;

endpackage

`default_nettype wire

// File: rtl/systolic_array_os_ctrl_if.sv
// ============================================================================
// Module      : systolic_array_os_ctrl_if
// Description : Scheduler, operand-buffer and array-edge signals of the
//               systolic array sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface systolic_array_os_ctrl_if #(
   parameter int SA_ROWS = 4,
   parameter int SA_COLS = 4,
   parameter int K_WIDTH = 16
);
   logic                   i_start;
   logic [K_WIDTH-1:0]     i_k_len;
   logic                   o_busy;
   logic                   o_done;
   logic                   o_err;
   logic                   o_rd_en;
   logic [K_WIDTH-1:0]     o_rd_addr;
   logic [SA_ROWS-1:0]     o_valid_left;
   logic [SA_ROWS-1:0]     o_cmd_left;
   logic [SA_COLS-1:0]     o_valid_top;
   logic [2*SA_COLS-1:0]   o_cmd_top;
   logic [SA_COLS-1:0]     i_valid_down;

   modport master (
      input  i_start, i_k_len, i_valid_down,
      output o_busy, o_done, o_err, o_rd_en, o_rd_addr,
             o_valid_left, o_cmd_left, o_valid_top, o_cmd_top
   );

   modport slave (
      output i_start, i_k_len, i_valid_down,
      input  o_busy, o_done, o_err, o_rd_en, o_rd_addr,
             o_valid_left, o_cmd_left, o_valid_top, o_cmd_top
   );
endinterface

`default_nettype wire

// File: rtl/sa_skew_line.sv
// ============================================================================
// Module      : sa_skew_line
// Description : Triangular shift register; lane i is the input delayed by
//               i cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_skew_line #(
   parameter int LANES = 4,
   parameter int W     = 1
) (
   input  wire logic                 clk,
   input  wire logic                 rst,
   input  wire logic [W-1:0]         i_data,
   output logic      [LANES*W-1:0]   o_lanes
);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      if (i == 0) begin : g_pass
         assign o_lanes[0 +: W] = i_data;
      end else begin : g_dly
         logic [W-1:0] sr_q [i];
         logic [W-1:0] sr_d [i];

         always_comb begin
            sr_d[0] = i_data;
            for (int j = 1; j < i; j++) begin
               sr_d[j] = sr_q[j-1];
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sr_q <= '{default: '0};
            end else begin
               sr_q <= sr_d;
            end
         end

         assign o_lanes[i*W +: W] = sr_q[i-1];
      end
   end

endmodule

`default_nettype wire

// File: rtl/systolic_array_os_ctrl.sv
// ============================================================================
// Module      : systolic_array_os_ctrl
// Description : Output-stationary systolic array sequencer: feed, wait,
//               flush and drain phases with skewed edge wavefronts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_array_os_ctrl
   import sa_ctrl_pkg::*;
#(
   parameter int SA_ROWS = 4,
   parameter int SA_COLS = 4,
   parameter int K_WIDTH = 16,
   parameter int RD_LAT  = 1
) (
   input wire logic                clk,
   input wire logic                rst,
   systolic_array_os_ctrl_if.master bus
);

   localparam int WAIT_W = $clog2(SA_ROWS + SA_COLS + 1);
   localparam int DRN_W  = $clog2(SA_ROWS + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(SA_ROWS + SA_COLS - 2);
   localparam logic [WAIT_W-1:0] FLUSH_LAST = WAIT_W'(SA_ROWS - 1);
   localparam logic [DRN_W-1:0]  DRN_LAST   = DRN_W'(SA_ROWS - 1);

   state_e              state_q, state_d;
   logic [K_WIDTH-1:0]  k_q, k_d;
   logic [K_WIDTH-1:0]  addr_q, addr_d;
   logic                rd_en_q, rd_en_d;
   logic [WAIT_W-1:0]   cnt_q, cnt_d;
   logic [DRN_W-1:0]    drn_q, drn_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic                w_base_valid;
   logic [1:0]          w_base_cmd;
   logic [SA_ROWS-1:0]  w_valid_left;
   logic                w_unused_down;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      addr_d  = addr_q;
      rd_en_d = rd_en_q;
      cnt_d   = cnt_q;
      drn_d   = drn_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.i_start) begin
               if (bus.i_k_len == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d = FEED;
                  k_d     = bus.i_k_len;
                  addr_d  = '0;
                  rd_en_d = 1'b1;
                  busy_d  = 1'b1;
               end
            end
         end
         FEED: begin
            if (addr_q == k_q - K_WIDTH'(1)) begin
               state_d = WAIT;
               rd_en_d = 1'b0;
               addr_d  = '0;
               cnt_d   = '0;
            end else begin
               addr_d  = addr_q + K_WIDTH'(1);
            end
         end
         WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               state_d = FLUSH;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + WAIT_W'(1);
            end
         end
         FLUSH: begin
            if (cnt_q == FLUSH_LAST) begin
               state_d = DRAIN;
               cnt_d   = '0;
               drn_d   = '0;
            end else begin
               cnt_d   = cnt_q + WAIT_W'(1);
            end
         end
         DRAIN: begin
            // Only the last column's bottom-edge valid marks a drained row.
            if (bus.i_valid_down[SA_COLS-1]) begin
               if (drn_q == DRN_LAST) begin
                  state_d = DONE;
                  drn_d   = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  drn_d   = drn_q + DRN_W'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         addr_q  <= '0;
         rd_en_q <= 1'b0;
         cnt_q   <= '0;
         drn_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         addr_q  <= addr_d;
         rd_en_q <= rd_en_d;
         cnt_q   <= cnt_d;
         drn_q   <= drn_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Operand data returns RD_LAT cycles after the read enable.
   if (RD_LAT == 0) begin : g_lat0
      assign w_base_valid = rd_en_q;
   end else begin : g_lat
      logic [RD_LAT-1:0] lat_q, lat_d;

      always_comb begin
         lat_d = RD_LAT'({lat_q, rd_en_q});
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            lat_q <= '0;
         end else begin
            lat_q <= lat_d;
         end
      end

      assign w_base_valid = lat_q[RD_LAT-1];
   end

   always_comb begin
      w_base_cmd = CMD_IDLE;
      if (w_base_valid) begin
         w_base_cmd = CMD_ACC;
      end else if (state_q == FLUSH) begin
         w_base_cmd = CMD_FLUSH;
      end
   end

   sa_skew_line #(.LANES(SA_ROWS), .W(1)) u_skew_left (
      .clk     (clk),
      .rst     (rst),
      .i_data  (w_base_valid),
      .o_lanes (w_valid_left)
   );

   sa_skew_line #(.LANES(SA_COLS), .W(1)) u_skew_top_valid (
      .clk     (clk),
      .rst     (rst),
      .i_data  (w_base_valid),
      .o_lanes (bus.o_valid_top)
   );

   sa_skew_line #(.LANES(SA_COLS), .W(2)) u_skew_top_cmd (
      .clk     (clk),
      .rst     (rst),
      .i_data  (w_base_cmd),
      .o_lanes (bus.o_cmd_top)
   );

   assign bus.o_valid_left = w_valid_left;
   assign bus.o_cmd_left   = w_valid_left;
   assign bus.o_busy       = busy_q;
   assign bus.o_done       = done_q;
   assign bus.o_err        = err_q;
   assign bus.o_rd_en      = rd_en_q;
   assign bus.o_rd_addr    = addr_q;

   assign w_unused_down = &{1'b0, bus.i_valid_down};

endmodule

`default_nettype wire

// File: tb/tb_systolic_array_os_ctrl.sv
// ============================================================================
// Module      : tb_systolic_array_os_ctrl
// Description : Self-checking bench for the systolic array sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_array_os_ctrl;

   localparam int R  = 4;
   localparam int C  = 4;
   localparam int KW = 16;
   localparam int RL = 1;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   int   job   = 0;

   always #5 clk = ~clk;

   systolic_array_os_ctrl_if #(.SA_ROWS(R), .SA_COLS(C), .K_WIDTH(KW)) bus ();

   systolic_array_os_ctrl #(
      .SA_ROWS (R),
      .SA_COLS (C),
      .K_WIDTH (KW),
      .RD_LAT  (RL)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " busy"},       bus.o_busy,       '0);
      chk({tag, " done"},       bus.o_done,       '0);
      chk({tag, " err"},        bus.o_err,        '0);
      chk({tag, " rd_en"},      bus.o_rd_en,      '0);
      chk({tag, " rd_addr"},    bus.o_rd_addr,    '0);
      chk({tag, " valid_left"}, bus.o_valid_left, '0);
      chk({tag, " cmd_left"},   bus.o_cmd_left,   '0);
      chk({tag, " valid_top"},  bus.o_valid_top,  '0);
      chk({tag, " cmd_top"},    bus.o_cmd_top,    '0);
   endtask

   // Expected edge activity at cycle t of a job (start accepted at cycle 0).
   task automatic check_cycle(input int t, input int k, input int done_t);
      int             f, lo, hi;
      bit             feeding;
      logic [R-1:0]   vl;
      logic [C-1:0]   vt;
      logic [2*C-1:0] ct;
      string          tg;
      tg      = $sformatf("job%0d t%0d", job, t);
      f       = 1 + k + (R + C - 1);
      lo      = 1 + RL;
      hi      = k + RL;
      feeding = (k != 0) && (t >= 1) && (t <= k);
      vl = '0;
      vt = '0;
      ct = '0;
      if (k != 0) begin
         for (int r = 0; r < R; r++) begin
            if (t - r >= lo && t - r <= hi) vl[r] = 1'b1;
         end
         for (int c = 0; c < C; c++) begin
            if (t - c >= lo && t - c <= hi) begin
               vt[c]        = 1'b1;
               ct[2*c +: 2] = 2'b01;
            end else if (t - c >= f && t - c < f + R) begin
               ct[2*c +: 2] = 2'b11;
            end
         end
      end
      chk({tg, " busy"},       bus.o_busy,       64'((k != 0) && (t >= 1) && (t < done_t)));
      chk({tg, " done"},       bus.o_done,       64'(t == done_t));
      chk({tg, " err"},        bus.o_err,        64'((t == done_t) && (k == 0)));
      chk({tg, " rd_en"},      bus.o_rd_en,      64'(feeding));
      if (feeding) chk({tg, " rd_addr"}, bus.o_rd_addr, 64'(t - 1));
      chk({tg, " valid_left"}, bus.o_valid_left, 64'(vl));
      chk({tg, " cmd_left"},   bus.o_cmd_left,   64'(vl));
      chk({tg, " valid_top"},  bus.o_valid_top,  64'(vt));
      chk({tg, " cmd_top"},    bus.o_cmd_top,    64'(ct));
   endtask

   // Runs one job from cycle 0 (DUT idle, caller positioned just after an edge).
   task automatic run_job(input int k, input bit hold, input bit stray, input bit fixed_drain);
      int         f, d, done_t, p;
      int         pulses[$];
      bit         hit;
      logic [C-1:0] vd;
      job++;
      f = 1 + k + (R + C - 1);
      d = f + R;
      if (k == 0) begin
         done_t = 1;
      end else begin
         p = fixed_drain ? d + 2 : d + int'($urandom_range(0, 3));
         for (int i = 0; i < R; i++) begin
            pulses.push_back(p);
            p += fixed_drain ? 1 : int'($urandom_range(1, 3));
         end
         done_t = pulses[R-1] + 1;
      end
      bus.i_start      = 1'b1;
      bus.i_k_len      = KW'(k);
      bus.i_valid_down = '0;
      check_cycle(0, k, done_t);
      for (int t = 1; t <= done_t; t++) begin
         step();
         if (hold) begin
            bus.i_start = 1'b1;
            bus.i_k_len = KW'($urandom);
         end else begin
            bus.i_start = 1'b0;
         end
         vd        = '0;
         vd[C-2:0] = (C-1)'($urandom);
         hit = 1'b0;
         foreach (pulses[i]) if (pulses[i] == t) hit = 1'b1;
         if (hit) begin
            vd[C-1] = 1'b1;
         end else if (stray && t < d && $urandom_range(0, 1) == 1) begin
            vd[C-1] = 1'b1;
         end
         bus.i_valid_down = vd;
         check_cycle(t, k, done_t);
      end
      step();
      bus.i_valid_down = '0;
   endtask

   initial begin
      rst              = 1'b1;
      bus.i_start      = 1'b0;
      bus.i_k_len      = '0;
      bus.i_valid_down = '0;
      repeat (2) step();
      chk_all_zero("reset");
      rst = 1'b0;
      step();
      chk_all_zero("idle");

      // K=8 with drain pulses at cycles 22..25
      run_job(8, 1'b0, 1'b0, 1'b1);
      // K=0 rejected
      run_job(0, 1'b0, 1'b0, 1'b0);
      // start held through a K=8 job, next job directly after done
      run_job(8, 1'b1, 1'b0, 1'b0);
      run_job(int'($urandom_range(1, 12)), 1'b0, 1'b0, 1'b0);

      // reset in the middle of a K=8 job
      bus.i_start = 1'b1;
      bus.i_k_len = KW'(8);
      step();
      bus.i_start = 1'b0;
      repeat (9) step();
      chk("pre_rst busy", bus.o_busy, 64'(1));
      rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      step();
      chk_all_zero("rst_hold");
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("post_rst%0d done", i), bus.o_done, '0);
         chk($sformatf("post_rst%0d busy", i), bus.o_busy, '0);
      end
      run_job(2, 1'b0, 1'b0, 1'b0);

      // stray last-column pulses before DRAIN
      run_job(8, 1'b0, 1'b1, 1'b0);
      // single-slice job
      run_job(1, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 6; i++) begin
         run_job(int'($urandom_range(1, 20)), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
      run_job(0, 1'b0, 1'b0, 1'b0);

      bus.i_start = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
